pipelined_cla_addsub: RTL

- Parametrised, pipelined successor to the team's 16-bit two-level carry-lookahead adder.
- Adds or subtracts WIDTH-bit operands using a 4-bit-group / 16-bit-block lookahead hierarchy inside each pipeline stage.
- Registers the inter-block carry between stages, one 16-bit slice per stage.
- Uses valid/ready handshakes on both sides and reports carry, signed overflow and zero flags. Used as the datapath adder in ALU and accumulator blocks.

---
 rtl/pipelined_cla_addsub_if.sv | 36 +++
 rtl/pipelined_cla_addsub.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for pipelined_cla_addsub.
// Signals:
//   in_valid/in_ready   operand beat handshake (in_ready driven by the adder)
//   in_a, in_b         WIDTH-bit operands
//   in_cin             carry-in, only honoured for additions
//   in_sub             1 = A-B, 0 = A+B+cin
//   out_valid/out_ready result beat handshake (out_ready driven by the consumer)
//   out_sum            WIDTH-bit result
//   out_cout/out_ovf/out_zero  carry-out, signed overflow, zero flags
// Modports: master = operand producer / result consumer, slave = the adder.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Each pipeline stage resolves one SLICE-bit (16-bit) slice with a
// 4-bit-group / 16-bit-block lookahead network; the slice carry-out is
// registered and consumed by the next stage. Unprocessed operand bits are
// carried forward shifted down (skew) and finished result slices are carried
// forward in place (de-skew), so the final stage presents an aligned result.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears every stage
//   bus  slave side of pipelined_cla_addsub_if (valid/ready in and out,
//        operands, result and carry/overflow/zero flags)
// Latency is NSTG = WIDTH/SLICE cycles, throughput one beat per cycle.
module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_cla_addsub_if.slave    bus
);
  localparam int NSTG = WIDTH / SLICE;

  if (SLICE != 16 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of SLICE, SLICE must be 16");
  end

  // One 16-bit slice: returns {carry into slice MSB, carry out, sum}.
  function automatic logic [SLICE+1:0] cla_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             c
  );
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [3:0]       gp;
    logic [3:0]       gg;
    logic [4:0]       cg;
    logic [SLICE:0]   cb;
    logic             bp;
    logic             bg;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Block lookahead: every group carry-in directly from the slice carry-in.
    bg = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
    bp = &gp;
    cg[0] = c;
    cg[1] = gg[0] | (gp[0] & c);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c);
    cg[4] = bg | (bp & c);
    for (int j = 0; j < 4; j++) begin
      cb[4*j] = cg[j];
      for (int i = 0; i < 3; i++) begin
        cb[4*j+i+1] = g[4*j+i] | (p[4*j+i] & cb[4*j+i]);
      end
    end
    cb[SLICE] = cg[4];
    return {cb[SLICE-1], cb[SLICE], p ^ cb[SLICE-1:0]};
  endfunction

  logic advance;

  // Stage registers.
  logic             valid_reg [NSTG];
  logic [WIDTH-1:0] a_reg     [NSTG];
  logic [WIDTH-1:0] b_reg     [NSTG];
  logic [WIDTH-1:0] sum_reg   [NSTG];
  logic             c_reg     [NSTG];
  logic             ovf_reg   [NSTG];

  // Per-stage sources (predecessor) and next values.
  logic             v_src     [NSTG];
  logic [WIDTH-1:0] a_src     [NSTG];
  logic [WIDTH-1:0] b_src     [NSTG];
  logic [WIDTH-1:0] sum_src   [NSTG];
  logic             c_src     [NSTG];
  logic [WIDTH-1:0] a_next    [NSTG];
  logic [WIDTH-1:0] b_next    [NSTG];
  logic [WIDTH-1:0] sum_next  [NSTG];
  logic             c_next    [NSTG];
  logic             ovf_next  [NSTG];

  assign advance = bus.out_ready | ~bus.out_valid;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    logic [SLICE+1:0] res;

    if (gi == 0) begin : g_first
      // Subtraction is A + ~B + 1.
      assign v_src[gi]   = bus.in_valid;
      assign a_src[gi]   = bus.in_a;
      assign b_src[gi]   = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign c_src[gi]   = bus.in_sub | bus.in_cin;
      assign sum_src[gi] = '0;
    end else begin : g_rest
      assign v_src[gi]   = valid_reg[gi-1];
      assign a_src[gi]   = a_reg[gi-1];
      assign b_src[gi]   = b_reg[gi-1];
      assign c_src[gi]   = c_reg[gi-1];
      assign sum_src[gi] = sum_reg[gi-1];
    end

    assign res = cla_slice(a_src[gi][SLICE-1:0], b_src[gi][SLICE-1:0], c_src[gi]);

    // Operands are shifted so the next stage always works on the low slice.
    assign a_next[gi]   = a_src[gi] >> SLICE;
    assign b_next[gi]   = b_src[gi] >> SLICE;
    // Slice gi of sum_src is still zero, so OR-ing drops the new slice in place.
    assign sum_next[gi] = sum_src[gi] | ({{(WIDTH-SLICE){1'b0}}, res[SLICE-1:0]} << (gi*SLICE));
    assign c_next[gi]   = res[SLICE];
    assign ovf_next[gi] = res[SLICE+1] ^ res[SLICE];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        valid_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        sum_reg[k]   <= '0;
        c_reg[k]     <= 1'b0;
        ovf_reg[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < NSTG; k++) begin
        valid_reg[k] <= v_src[k];
        a_reg[k]     <= a_next[k];
        b_reg[k]     <= b_next[k];
        sum_reg[k]   <= sum_next[k];
        c_reg[k]     <= c_next[k];
        ovf_reg[k]   <= ovf_next[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_reg[NSTG-1];
  assign bus.out_sum   = sum_reg[NSTG-1];
  assign bus.out_cout  = c_reg[NSTG-1];
  assign bus.out_ovf   = ovf_reg[NSTG-1];
  // Gated with valid so the flag is 0 out of reset like the other flags.
  assign bus.out_zero  = valid_reg[NSTG-1] & ~(|sum_reg[NSTG-1]);
endmodule
